// File: rtl/gpi_mirror_debounce.sv
// GPI-to-GPO mirror: per-bit synchroniser and debouncer feeding a four-mode
// output bank, with a sticky, maskable edge interrupt.
module gpi_mirror_debounce #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      DEBOUNCE    = 16,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [WIDTH-1:0] gpi,
    input  logic [1:0]       mode,
    input  logic             snap,
    input  logic [1:0]       edge_sel,
    input  logic [WIDTH-1:0] irq_en,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] gpo,
    output logic [WIDTH-1:0] gpo_oeb,
    output logic [WIDTH-1:0] status,
    output logic             irq
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] db_prev_q, db_prev_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] gpo_q, gpo_d;
    logic [WIDTH-1:0] oeb_q, oeb_d;
    logic [WIDTH-1:0] rise, fall, set_v;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = gpi;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // A change is only accepted after DEBOUNCE consecutive differing samples.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_out[i] != db_q[i]) begin
                if (cnt_q[i] + CNT_ONE == CNT_MAX) begin
                    db_d[i] = sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        db_prev_d = db_q;
        rise      = db_q & ~db_prev_q;
        fall      = ~db_q & db_prev_q;
        set_v     = (rise & {WIDTH{edge_sel[0]}})
                  | (fall & {WIDTH{edge_sel[1]}});
        // Set has priority over a coincident clear.
        status_d  = set_v | (status_q & ~irq_clr);
        irq_d     = |(status_q & irq_en);
        snap_d    = snap ? db_q : snap_q;
    end

    always_comb begin
        gpo_d = '0;
        oeb_d = '1;
        unique case (mode)
            2'd0: begin
                gpo_d = '0;
                oeb_d = '1;
            end
            2'd1: begin
                gpo_d = db_q;
                oeb_d = '0;
            end
            2'd2: begin
                gpo_d = ~db_q;
                oeb_d = '0;
            end
            2'd3: begin
                gpo_d = snap_q;
                oeb_d = '0;
            end
            default: begin
                gpo_d = '0;
                oeb_d = '1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_VAL;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            db_q      <= RESET_VAL;
            db_prev_q <= RESET_VAL;
            snap_q    <= RESET_VAL;
            status_q  <= '0;
            irq_q     <= 1'b0;
            gpo_q     <= '0;
            oeb_q     <= '1;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            snap_q    <= snap_d;
            status_q  <= status_d;
            irq_q     <= irq_d;
            gpo_q     <= gpo_d;
            oeb_q     <= oeb_d;
        end
    end

    assign gpo     = gpo_q;
    assign gpo_oeb = oeb_q;
    assign status  = status_q;
    assign irq     = irq_q;

endmodule
